// File: rtl/tcp_vlg_ka_tx.sv
// TCP keep-alive transmitter: builds an ACK-only header, arbitrates for the TX path, reports completion.
// Define TCP_VLG_KA_GARBAGE_EN to emit a one-byte (8'h00) garbage-octet keep-alive instead of a zero-length one.

package tcp_vlg_ka_pkg;

    typedef enum logic [2:0] {
        tcp_closed,
        tcp_listening,
        tcp_connecting,
        tcp_connected,
        tcp_disconnecting
    } tcp_stat_t;

    typedef struct packed {
        logic [31:0] rem_ipv4;
        logic [15:0] loc_port;
        logic [15:0] rem_port;
        logic [31:0] loc_seq;
        logic [31:0] loc_ack;
    } tcb_t;

    typedef struct packed {
        logic ns;
        logic cwr;
        logic ece;
        logic urg;
        logic ack;
        logic psh;
        logic rst;
        logic syn;
        logic fin;
    } tcp_flags_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] tcp_seq_num;
        logic [31:0] tcp_ack_num;
        logic [3:0]  tcp_offset;
        logic [2:0]  reserved;
        tcp_flags_t  tcp_flags;
        logic [15:0] tcp_win_size;
        logic [15:0] tcp_cks;
        logic [15:0] tcp_pointer;
    } tcp_hdr_t;

endpackage

module tcp_vlg_ka_tx
    import tcp_vlg_ka_pkg::*;
#(
    parameter int unsigned GNT_TIMEOUT = 1250,
    parameter logic [15:0] WINDOW      = 16'hffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  tcb_t        tcb,
    input  tcp_stat_t   status,
    input  logic        send,
    output logic        sent,
    output logic        ka_req,
    input  logic        ka_gnt,
    input  logic        ka_done,
    output tcp_hdr_t    ka_hdr,
    output logic [31:0] ka_ipv4,
    output logic [15:0] ka_len,
    output logic        ka_err,
    output logic [15:0] ka_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XMIT, ST_DONE} state_e;

`ifdef TCP_VLG_KA_GARBAGE_EN
    localparam logic [15:0] KA_LEN = 16'd1;
`else
    localparam logic [15:0] KA_LEN = 16'd0;
`endif

    localparam int unsigned TW = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(GNT_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        ign_q, ign_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    tcp_hdr_t    hdr_q, hdr_d;
    logic [31:0] ipv4_q, ipv4_d;
    logic [15:0] len_q, len_d;
    logic        connected;

    assign connected = (status == tcp_connected);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            ign_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            hdr_q   <= '0;
            ipv4_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ign_q   <= ign_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            ipv4_q  <= ipv4_d;
            len_q   <= len_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        ign_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        ipv4_d  = ipv4_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                // ign_q masks the cycle in which the timer is still deasserting send.
                if (send && connected && !ign_q) begin
                    state_d               = ST_REQ;
                    hdr_d                 = '0;
                    hdr_d.src_port        = tcb.loc_port;
                    hdr_d.dst_port        = tcb.rem_port;
                    hdr_d.tcp_seq_num     = tcb.loc_seq - 32'd1;
                    hdr_d.tcp_ack_num     = tcb.loc_ack;
                    hdr_d.tcp_offset      = 4'd5;
                    hdr_d.tcp_flags.ack   = 1'b1;
                    hdr_d.tcp_win_size    = WINDOW;
                    ipv4_d                = tcb.rem_ipv4;
                    len_d                 = KA_LEN;
                end
            end
            ST_REQ: begin
                if (!connected) begin
                    state_d = ST_IDLE;
                end else if (ka_gnt) begin
                    state_d = ST_XMIT;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_XMIT: begin
                if (!connected) begin
                    state_d = ST_IDLE;
                end else if (ka_done) begin
                    state_d = ST_DONE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ign_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ka_req  = (state_q == ST_REQ);
        sent    = (state_q == ST_DONE);
        ka_err  = err_q;
        ka_cnt  = cnt_q;
        ka_hdr  = hdr_q;
        ka_ipv4 = ipv4_q;
        ka_len  = len_q;
    end

endmodule

// File: tb/tb_tcp_vlg_ka_tx.sv
// Scoreboard bench for tcp_vlg_ka_tx: directed transactions push expectations, a monitor checks each sent pulse.
// Honours TCP_VLG_KA_GARBAGE_EN for the expected payload length.
module tb_tcp_vlg_ka_tx;
    import tcp_vlg_ka_pkg::*;

    localparam int unsigned TO = 8;

`ifdef TCP_VLG_KA_GARBAGE_EN
    localparam logic [15:0] EXP_LEN = 16'd1;
`else
    localparam logic [15:0] EXP_LEN = 16'd0;
`endif

    typedef struct {
        logic        err;
        logic [15:0] cnt;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] ipv4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    tcb_t        tcb;
    tcp_stat_t   status;
    logic        send, sent, ka_req, ka_gnt, ka_done, ka_err;
    tcp_hdr_t    ka_hdr;
    logic [31:0] ka_ipv4;
    logic [15:0] ka_len, ka_cnt;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    tcp_vlg_ka_tx #(.GNT_TIMEOUT(TO), .WINDOW(16'hffff)) dut (
        .clk(clk), .rst_n(rst_n), .tcb(tcb), .status(status), .send(send), .sent(sent),
        .ka_req(ka_req), .ka_gnt(ka_gnt), .ka_done(ka_done), .ka_hdr(ka_hdr),
        .ka_ipv4(ka_ipv4), .ka_len(ka_len), .ka_err(ka_err), .ka_cnt(ka_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic err, input logic [15:0] cnt, input logic [31:0] seq);
        exp_t e;
        e.err  = err;
        e.cnt  = cnt;
        e.seq  = seq;
        e.ack  = tcb.loc_ack;
        e.src  = tcb.loc_port;
        e.dst  = tcb.rem_port;
        e.ipv4 = tcb.rem_ipv4;
        sb_q.push_back(e);
    endtask

    // Monitor: every sent pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sent) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_sent", 64'(sent), 64'd0);
                end else begin
                    exp_t e;
                    tcp_flags_t f;
                    e = sb_q.pop_front();
                    f = '0;
                    f.ack = 1'b1;
                    check("mon_err",    64'(ka_err), 64'(e.err));
                    check("mon_cnt",    64'(ka_cnt), 64'(e.cnt));
                    check("mon_seq",    64'(ka_hdr.tcp_seq_num), 64'(e.seq));
                    check("mon_ack",    64'(ka_hdr.tcp_ack_num), 64'(e.ack));
                    check("mon_src",    64'(ka_hdr.src_port), 64'(e.src));
                    check("mon_dst",    64'(ka_hdr.dst_port), 64'(e.dst));
                    check("mon_flags",  64'(ka_hdr.tcp_flags), 64'(f));
                    check("mon_win",    64'(ka_hdr.tcp_win_size), 64'hffff);
                    check("mon_offset", 64'(ka_hdr.tcp_offset), 64'd5);
                    check("mon_ipv4",   64'(ka_ipv4), 64'(e.ipv4));
                    check("mon_len",    64'(ka_len), 64'(EXP_LEN));
                end
            end else if (ka_err) begin
                check("err_without_sent", 64'(ka_err), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        send    = 1'b0;
        ka_gnt  = 1'b0;
        ka_done = 1'b0;
        status  = tcp_closed;
        tcb     = '{rem_ipv4: 32'hc0a80001, loc_port: 16'h1234, rem_port: 16'h5678,
                    loc_seq: 32'h1000, loc_ack: 32'h2000};
        tick();
        tick();
        check("rst_sent",  64'(sent), 64'd0);
        check("rst_req",   64'(ka_req), 64'd0);
        check("rst_err",   64'(ka_err), 64'd0);
        check("rst_cnt",   64'(ka_cnt), 64'd0);
        check("rst_hdr",   64'(ka_hdr.tcp_seq_num), 64'd0);
        check("rst_ipv4",  64'(ka_ipv4), 64'd0);
        check("rst_len",   64'(ka_len), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic keep-alive: grant 2 cycles after REQ entry, done 10 cycles later.
        status = tcp_connected;
        push_exp(1'b0, 16'd1, 32'h0fff);
        send = 1'b1;
        tick();
        check("t1_req", 64'(ka_req), 64'd1);
        tick();
        ka_gnt = 1'b1;
        tick();
        ka_gnt = 1'b0;
        check("t1_req_drop", 64'(ka_req), 64'd0);
        tcb.loc_seq = 32'hdead0000;
        tick();
        check("t1_hdr_stable", 64'(ka_hdr.tcp_seq_num), 64'h0fff);
        tcb.loc_seq = 32'h1000;
        repeat (8) tick();
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        check("t1_sent", 64'(sent), 64'd1);
        tick();
        tick();
        send = 1'b0;
        check("t1_ignore_send", 64'(ka_req), 64'd0);
        tick();

        // Sequence wrap, immediate grant, stray ka_done during REQ ignored.
        tcb.loc_seq = 32'h0;
        push_exp(1'b0, 16'd2, 32'hffffffff);
        send = 1'b1;
        tick();
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        check("t2_done_ignored", 64'(ka_req), 64'd1);
        ka_gnt = 1'b1;
        tick();
        ka_gnt = 1'b0;
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        send = 1'b0;
        tick();
        tick();

        // Grant timeout: DONE with ka_err 8 cycles after REQ entry, count unchanged.
        tcb.loc_seq = 32'h5555;
        push_exp(1'b1, 16'd2, 32'h5554);
        send = 1'b1;
        tick();
        repeat (TO - 1) tick();
        check("t3_still_req", 64'(ka_req), 64'd1);
        check("t3_no_sent_early", 64'(sent), 64'd0);
        tick();
        check("t3_sent_err", 64'({sent, ka_err}), 64'b11);
        send = 1'b0;
        tick();
        check("t3_err_one_cycle", 64'(ka_err), 64'd0);
        tick();

        // Grant on the timeout cycle wins.
        push_exp(1'b0, 16'd3, 32'h5554);
        send = 1'b1;
        tick();
        repeat (TO - 1) tick();
        ka_gnt = 1'b1;
        tick();
        ka_gnt = 1'b0;
        check("t4_grant_wins", 64'({ka_req, sent, ka_err}), 64'b000);
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        send = 1'b0;
        tick();
        tick();

        // Connection drops in XMIT: back to IDLE, no sent, later ka_done ignored.
        send = 1'b1;
        tick();
        ka_gnt = 1'b1;
        tick();
        ka_gnt = 1'b0;
        status = tcp_closed;
        tick();
        send = 1'b0;
        check("t5_abort", 64'({ka_req, sent}), 64'b00);
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        tick();
        check("t5_cnt_kept", 64'(ka_cnt), 64'd3);

        // Reset during REQ clears everything at once.
        status = tcp_connected;
        send = 1'b1;
        tick();
        check("t6_req", 64'(ka_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", 64'({sent, ka_req, ka_err}), 64'd0);
        check("t6_rst_cnt", 64'(ka_cnt), 64'd0);
        check("t6_rst_hdr", 64'(ka_hdr.tcp_ack_num), 64'd0);
        check("t6_rst_len", 64'({ka_ipv4, ka_len}), 64'd0);
        send = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh transaction after reset behaves like power-up.
        tcb.loc_seq = 32'h0000_0100;
        push_exp(1'b0, 16'd1, 32'h0000_00ff);
        send = 1'b1;
        tick();
        ka_gnt = 1'b1;
        tick();
        ka_gnt = 1'b0;
        ka_done = 1'b1;
        tick();
        ka_done = 1'b0;
        send = 1'b0;
        tick();
        tick();

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
